// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the four-key debounce block.
// Channel order matches the board pins B2..B5 feeding the ColorBar key inputs.
package key_pkg;

    localparam int KEY_S_IDX = 0;
    localparam int KEY_D_IDX = 1;
    localparam int KEY_F_IDX = 2;
    localparam int KEY_G_IDX = 3;

    // Default timing at a 50 MHz system clock.
    localparam int DEB_CYCLES_DEF    = 1_000_000;  // 20 ms
    localparam int REPEAT_DELAY_DEF  = 25_000_000; // 500 ms
    localparam int REPEAT_PERIOD_DEF = 5_000_000;  // 100 ms

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bus between the board pins and the ColorBar pattern logic.
// master = board/stimulus side, slave = the debounce block.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (
        output key_n_raw,
        input  key_level,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  key_n_raw,
        output key_level,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce counter, press/release pulses.
// Optional auto-repeat of the press pulse when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int               DEB_W    = cnt_width(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // Reject unusable timing at elaboration.
    if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_debounce_ch: invalid timing parameters");
    end

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] deb_cnt;
    logic             pressed_s;
    logic             deb_done;
    logic             rpt_hit;

    always_comb begin
        pressed_s = ~sync2;
        deb_done  = (pressed_s != key_level) && (deb_cnt == DEB_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            deb_cnt     <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_n_raw;
            sync2       <= sync1;
            key_press   <= (deb_done & pressed_s) | rpt_hit;
            key_release <= deb_done & ~pressed_s;
            // Any return to the accepted level, or an accepted change, restarts the count.
            if (pressed_s == key_level || deb_done)
                deb_cnt <= '0;
            else
                deb_cnt <= deb_cnt + 1'b1;
            if (deb_done)
                key_level <= pressed_s;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;

    // deb_done while held is a release; it wins over a coincident repeat.
    always_comb begin
        rpt_hit = key_level && !deb_done &&
                  (rpt_cnt == (rpt_armed ? RPT_PER_LAST : RPT_DLY_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!key_level || deb_done) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Four-channel push-button conditioner: NUM_KEYS independent debounce channels.
// Build option: KEY_REPEAT_EN adds auto-repeat press pulses while a key is held.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic           clk,
    input  logic           reset,
    key_debounce_if.slave  kb
);

    logic [NUM_KEYS-1:0] lvl;
    logic [NUM_KEYS-1:0] prs;
    logic [NUM_KEYS-1:0] rel;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_n_raw   (kb.key_n_raw[i]),
            .key_level   (lvl[i]),
            .key_press   (prs[i]),
            .key_release (rel[i])
        );
    end

    assign kb.key_level   = lvl;
    assign kb.key_press   = prs;
    assign kb.key_release = rel;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: window-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed pulse timing.
module tb_key_debounce;
    import key_pkg::*;

    localparam int NK  = 4;
    localparam int DEB = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int HMAX = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw;

    key_debounce_if #(.NUM_KEYS(NK)) kb();
    assign kb.key_n_raw = raw;

    key_debounce #(
        .NUM_KEYS(NK), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kb    (kb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- model ----------------
    int       cyc = -1;
    bit [3:0] raw_h [HMAX];
    bit       rst_h [HMAX];
    bit [3:0] m_lvl = '0, m_prs = '0, m_rel = '0;
    int       last_evt [NK];
    int       p_edge   [NK];

    // Debounced-path view of key b at edge n: raw from two edges earlier, released around reset.
    function automatic bit ps(input int n, input int b);
        if (n < 2) return 1'b0;
        if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
        return ~raw_h[n-2][b];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow cycle=%0d limit=%0d", cyc, HMAX);
            $fatal(1);
        end
        raw_h[cyc] = raw;
        rst_h[cyc] = reset;
        for (int b = 0; b < NK; b++) begin
            bit v, chg;
            m_prs[b] = 1'b0;
            m_rel[b] = 1'b0;
            if (reset) begin
                m_lvl[b]    = 1'b0;
                last_evt[b] = cyc;
            end else begin
                v   = ps(cyc, b);
                chg = 1'b0;
                // Accept only after DEB consecutive edges of the new level since the last event.
                if (v != m_lvl[b] && cyc - last_evt[b] >= DEB) begin
                    chg = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (ps(cyc - k, b) != v) chg = 1'b0;
                end
                if (chg) begin
                    m_lvl[b]    = v;
                    last_evt[b] = cyc;
                    if (v) begin m_prs[b] = 1'b1; p_edge[b] = cyc; end
                    else   m_rel[b] = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                else if (m_lvl[b] && cyc - p_edge[b] >= RD &&
                         (cyc - p_edge[b] - RD) % RP == 0)
                    m_prs[b] = 1'b1;
`endif
            end
        end
    end

    // ---------------- compare + pulse log ----------------
    int prs_cnt [NK] = '{default: 0};
    int rel_cnt [NK] = '{default: 0};
    int prs_last[NK] = '{default: -1};
    int rel_last[NK] = '{default: -1};
    int prs_q[$];

    always @(negedge clk) begin
        if (cyc >= 0) begin
            total++;
            if ({kb.key_level, kb.key_press, kb.key_release} !== {m_lvl, m_prs, m_rel}) begin
                bad++;
                $display("FAIL cycle_%0d lvl/prs/rel got %b/%b/%b want %b/%b/%b", cyc,
                         kb.key_level, kb.key_press, kb.key_release, m_lvl, m_prs, m_rel);
            end
            for (int b = 0; b < NK; b++) begin
                if (kb.key_press[b] === 1'b1) begin
                    prs_cnt[b]++; prs_last[b] = cyc;
                    if (b == KEY_S_IDX) prs_q.push_back(cyc);
                end
                if (kb.key_release[b] === 1'b1) begin
                    rel_cnt[b]++; rel_last[b] = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1, rst_e, p, t, base;
        raw   = 4'hF;
        reset = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        wait_neg(100);
        chk("idle_level", int'(kb.key_level), 0);
        chk("idle_press", prs_cnt[0] + prs_cnt[1] + prs_cnt[2] + prs_cnt[3], 0);
        chk("idle_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

        // Single press on S, then release.
        raw[KEY_S_IDX] = 1'b0; c0 = cyc + 1;
        wait_neg(20);
        chk("s_press_latency", prs_last[0] - c0, 9);
        chk("s_press_count", prs_cnt[0], 1);
        chk("s_level", int'(kb.key_level), 1);
        chk("s_others_quiet", prs_cnt[1] + prs_cnt[2] + prs_cnt[3], 0);
        raw[KEY_S_IDX] = 1'b1; c0 = cyc + 1;
        wait_neg(20);
        chk("s_release_latency", rel_last[0] - c0, 9);
        chk("s_release_count", rel_cnt[0], 1);
        chk("s_level_off", int'(kb.key_level), 0);

        // Bounce on D never settles long enough.
        raw[KEY_D_IDX] = 1'b0; wait_neg(5);
        raw[KEY_D_IDX] = 1'b1; wait_neg(2);
        raw[KEY_D_IDX] = 1'b0; wait_neg(5);
        raw[KEY_D_IDX] = 1'b1; wait_neg(20);
        chk("bounce_press", prs_cnt[1], 0);
        chk("bounce_release", rel_cnt[1], 0);

        // F and G together.
        raw[3:2] = 2'b00; c0 = cyc + 1;
        wait_neg(30);
        raw[3:2] = 2'b11; c1 = cyc + 1;
        wait_neg(20);
        chk("f_press_latency", prs_last[2] - c0, 9);
        chk("g_press_latency", prs_last[3] - c0, 9);
        chk("fg_press_count", prs_cnt[2] + prs_cnt[3], 2);
        chk("f_release_latency", rel_last[2] - c1, 9);
        chk("g_release_latency", rel_last[3] - c1, 9);
        chk("fg_release_count", rel_cnt[2] + rel_cnt[3], 2);

        // Reset while S is mid-count (counter = 5 after edge c0+6).
        raw[KEY_S_IDX] = 1'b0; c0 = cyc + 1;
        wait_neg(7);
        reset = 1'b1;
        wait_neg(1);
        rst_e = cyc;
        reset = 1'b0;
        chk("rst_level", int'(kb.key_level), 0);
        chk("rst_no_press", prs_cnt[0], 1);
        base = prs_cnt[0];
        t = 0;
        while (prs_cnt[0] == base && t < 40) begin wait_neg(1); t++; end
        chk("rst_press_latency", prs_last[0] - rst_e, 10);

        // Hold S; release lands level-low exactly 100 edges after the press pulse.
        p = prs_last[0];
        t = 0;
        while (cyc < p + 90 && t < 200) begin wait_neg(1); t++; end
        raw[KEY_S_IDX] = 1'b1;
        wait_neg(40);
        chk("hold_release_offset", rel_last[0] - p, 100);
        chk("hold_release_count", rel_cnt[0], 2);
`ifdef KEY_REPEAT_EN
        chk("repeat_press_count", prs_cnt[0], 8);
        for (int i = 0; i < 6; i++)
            chk($sformatf("repeat_%0d_offset", i),
                (prs_q.size() > 2 + i) ? prs_q[2 + i] - p : -1, RD + RP * i);
`else
        chk("no_repeat_count", prs_cnt[0], 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
